// File: rtl/block_sync_seeker.sv
// 64b/66b block-boundary seeker: parallel header hunt, lock declaration and error-rate unlock.
// Define SEEKER_STATS_EN to build the relock / locked-header-error statistics counters.
module block_sync_seeker #(
  parameter int unsigned BLOCK_W    = 66,
  parameter int unsigned N_SEEKERS  = 22,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned UNLOCK_BAD = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [BLOCK_W:0]           window_i,
  input  logic                       window_dv_i,
  input  logic                       force_hunt_i,
  output logic                       lock_o,
  output logic [$clog2(BLOCK_W)-1:0] offset_o,
  output logic                       hdr_dv_o,
  output logic                       hdr_ok_o,
  output logic [15:0]                relock_cnt_o,
  output logic [15:0]                hdr_err_cnt_o
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_W);
  localparam int unsigned N_CAND = BLOCK_W / N_SEEKERS;
  localparam int unsigned CAND_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;
  localparam int unsigned CNT_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MON_W  = $clog2(WINDOW + 1);

  localparam logic [CNT_W-1:0]  LOCK_MAX   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  LOCK_PRE   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CAND_W-1:0] CAND_LAST  = CAND_W'(N_CAND - 1);
  localparam logic [MON_W-1:0]  WIN_LAST   = MON_W'(WINDOW - 1);
  localparam logic [MON_W-1:0]  UNLOCK_PRE = MON_W'(UNLOCK_BAD - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [BLOCK_W:0]   win_q;
  logic               eval_q;
  logic [CNT_W-1:0]   cnt_q  [N_SEEKERS];
  logic [CNT_W-1:0]   cnt_d  [N_SEEKERS];
  logic [CAND_W-1:0]  cand_q [N_SEEKERS];
  logic [CAND_W-1:0]  cand_d [N_SEEKERS];
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic [MON_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [MON_W-1:0]   bad_cnt_q, bad_cnt_d;
  logic               lock_q;
  logic               hdr_dv_q, hdr_dv_d;
  logic               hdr_ok_q, hdr_ok_d;

  logic [OFF_W-1:0]   seek_off [N_SEEKERS];
  logic               seek_ok  [N_SEEKERS];
  logic               seek_hit [N_SEEKERS];
  logic               lock_hit;
  logic [OFF_W-1:0]   win_off;
  logic               mon_ok;
  logic               unlock_hit;

  // A sync header is valid when its two bits differ (01 data, 10 command).
  function automatic logic hdr_valid(input logic [BLOCK_W:0] w, input logic [OFF_W-1:0] off);
    logic [BLOCK_W:0] sh;
    sh = w >> off;
    return sh[1] ^ sh[0];
  endfunction

  // Window capture: everything downstream evaluates the registered copy one edge later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q  <= '0;
      eval_q <= 1'b0;
    end else begin
      eval_q <= window_dv_i;
      if (window_dv_i) begin
        win_q <= window_i;
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N_SEEKERS; j++) begin
      seek_off[j] = OFF_W'(32'(cand_q[j]) * N_SEEKERS + j);
      seek_ok[j]  = hdr_valid(win_q, seek_off[j]);
      seek_hit[j] = seek_ok[j] && (cnt_q[j] == LOCK_PRE);
    end
  end

  // Lowest-numbered seeker reaching LOCK_CNT supplies the lock offset.
  always_comb begin
    lock_hit = 1'b0;
    win_off  = '0;
    for (int unsigned j = 0; j < N_SEEKERS; j++) begin
      if (seek_hit[j] && !lock_hit) begin
        lock_hit = 1'b1;
        win_off  = seek_off[j];
      end
    end
  end

  assign mon_ok     = hdr_valid(win_q, offset_q);
  assign unlock_hit = !mon_ok && (bad_cnt_q == UNLOCK_PRE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: begin
        if (!force_hunt_i && eval_q && lock_hit) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (force_hunt_i || (eval_q && unlock_hit)) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    offset_d  = offset_q;
    hdr_cnt_d = hdr_cnt_q;
    bad_cnt_d = bad_cnt_q;
    hdr_dv_d  = 1'b0;
    hdr_ok_d  = 1'b0;
    if (force_hunt_i) begin
      for (int unsigned j = 0; j < N_SEEKERS; j++) begin
        cnt_d[j]  = '0;
        cand_d[j] = '0;
      end
    end else if (eval_q) begin
      unique case (state_q)
        HUNT: begin
          if (lock_hit) begin
            offset_d  = win_off;
            hdr_cnt_d = '0;
            bad_cnt_d = '0;
            for (int unsigned j = 0; j < N_SEEKERS; j++) begin
              cnt_d[j]  = '0;
              cand_d[j] = '0;
            end
          end else begin
            for (int unsigned j = 0; j < N_SEEKERS; j++) begin
              if (seek_ok[j]) begin
                if (cnt_q[j] != LOCK_MAX) begin
                  cnt_d[j] = cnt_q[j] + 1'b1;
                end
              end else begin
                cnt_d[j]  = '0;
                cand_d[j] = (cand_q[j] == CAND_LAST) ? '0 : cand_q[j] + 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          hdr_dv_d = 1'b1;
          hdr_ok_d = mon_ok;
          if (unlock_hit || (hdr_cnt_q == WIN_LAST)) begin
            hdr_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 1'b1;
            if (!mon_ok) begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned j = 0; j < N_SEEKERS; j++) begin
        cnt_q[j]  <= '0;
        cand_q[j] <= '0;
      end
      offset_q  <= '0;
      hdr_cnt_q <= '0;
      bad_cnt_q <= '0;
      lock_q    <= 1'b0;
      hdr_dv_q  <= 1'b0;
      hdr_ok_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      offset_q  <= offset_d;
      hdr_cnt_q <= hdr_cnt_d;
      bad_cnt_q <= bad_cnt_d;
      lock_q    <= (state_d == LOCKED);
      hdr_dv_q  <= hdr_dv_d;
      hdr_ok_q  <= hdr_ok_d;
    end
  end

  assign lock_o   = lock_q;
  assign offset_o = offset_q;
  assign hdr_dv_o = hdr_dv_q;
  assign hdr_ok_o = hdr_ok_q;

`ifdef SEEKER_STATS_EN
  logic [15:0] relock_q;
  logic [15:0] err_q;

  // Saturating statistics; cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      relock_q <= '0;
      err_q    <= '0;
    end else begin
      if ((state_q == HUNT) && (state_d == LOCKED) && (relock_q != 16'hFFFF)) begin
        relock_q <= relock_q + 16'd1;
      end
      if (hdr_dv_d && !hdr_ok_d && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  assign relock_cnt_o  = relock_q;
  assign hdr_err_cnt_o = err_q;
`else
  assign relock_cnt_o  = '0;
  assign hdr_err_cnt_o = '0;
`endif

endmodule
